apb_master_arbiter: RTL and testbench

- Two-requester APB master that shares one APB bus among up to four slaves.
- Each requester (e.g. the I2C controller and a host/test port) presents a command with a slave id. The block arbitrates round-robin and sequences the APB SETUP/ACCESS phases.
- It honours slave wait states from ready, returns read data, and aborts hung transfers after a programmable timeout.

---
 rtl/apb_master_arbiter_if.sv | 52 +++++
 rtl/apb_master_arbiter.sv | 129 ++++++++++++
 tb/tb_apb_master_arbiter.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_arbiter_if.sv
// Requester command/response signals and the shared APB bus for apb_master_arbiter.
// The master modport is the arbiter's view; the slave modport is the environment's view.
interface apb_master_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              r0_valid;
    logic              r0_write;
    logic [1:0]        r0_id;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_wdata;
    logic              r0_ack;
    logic              r0_done;
    logic [DATA_W-1:0] r0_rdata;
    logic              r0_err;

    logic              r1_valid;
    logic              r1_write;
    logic [1:0]        r1_id;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_wdata;
    logic              r1_ack;
    logic              r1_done;
    logic [DATA_W-1:0] r1_rdata;
    logic              r1_err;

    logic [3:0]        apb_sel;
    logic              apb_enable;
    logic              apb_write;
    logic [ADDR_W-1:0] apb_addr;
    logic [DATA_W-1:0] apb_wdata;
    logic [DATA_W-1:0] apb_rdata;
    logic              apb_ready;

    modport master (
        input  r0_valid, r0_write, r0_id, r0_addr, r0_wdata,
        input  r1_valid, r1_write, r1_id, r1_addr, r1_wdata,
        input  apb_rdata, apb_ready,
        output r0_ack, r0_done, r0_rdata, r0_err,
        output r1_ack, r1_done, r1_rdata, r1_err,
        output apb_sel, apb_enable, apb_write, apb_addr, apb_wdata
    );

    modport slave (
        output r0_valid, r0_write, r0_id, r0_addr, r0_wdata,
        output r1_valid, r1_write, r1_id, r1_addr, r1_wdata,
        output apb_rdata, apb_ready,
        input  r0_ack, r0_done, r0_rdata, r0_err,
        input  r1_ack, r1_done, r1_rdata, r1_err,
        input  apb_sel, apb_enable, apb_write, apb_addr, apb_wdata
    );
endinterface

// File: rtl/apb_master_arbiter.sv
// Two-requester APB master: round-robin grant, SETUP/ACCESS sequencing,
// slave wait states and a wait-state timeout abort. All outputs are registered.
module apb_master_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int WAIT_MAX = 16
) (
    input logic clk,
    input logic reset,
    apb_master_arbiter_if.master bus
);
    localparam int CNT_W = $clog2(WAIT_MAX + 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t            state;
    logic              owner;
    logic              last_grant;
    logic [CNT_W-1:0]  wait_cnt;

    logic [3:0]        sel;
    logic              enable;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [1:0]        ack;
    logic [1:0]        done;
    logic [1:0]        err;
    logic [DATA_W-1:0] r0_rdata;
    logic [DATA_W-1:0] r1_rdata;

    logic              grant_any;
    logic              pick;
    logic              pick_write;
    logic [1:0]        pick_id;
    logic [ADDR_W-1:0] pick_addr;
    logic [DATA_W-1:0] pick_wdata;

    // On a tie the requester that was not granted last wins.
    always_comb begin
        grant_any  = bus.r0_valid | bus.r1_valid;
        pick       = (bus.r0_valid && bus.r1_valid) ? ~last_grant : bus.r1_valid;
        pick_write = pick ? bus.r1_write : bus.r0_write;
        pick_id    = pick ? bus.r1_id    : bus.r0_id;
        pick_addr  = pick ? bus.r1_addr  : bus.r0_addr;
        pick_wdata = pick ? bus.r1_wdata : bus.r0_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            wait_cnt   <= '0;
            sel        <= '0;
            enable     <= 1'b0;
            write      <= 1'b0;
            addr       <= '0;
            wdata      <= '0;
            ack        <= '0;
            done       <= '0;
            err        <= '0;
            r0_rdata   <= '0;
            r1_rdata   <= '0;
        end else begin
            ack  <= '0;
            done <= '0;
            err  <= '0;
            case (state)
                IDLE: begin
                    sel    <= '0;
                    enable <= 1'b0;
                    if (grant_any) begin
                        owner      <= pick;
                        last_grant <= pick;
                        write      <= pick_write;
                        addr       <= pick_addr;
                        wdata      <= pick_wdata;
                        sel        <= 4'b0001 << pick_id;
                        ack        <= pick ? 2'b10 : 2'b01;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    enable <= 1'b1;
                    state  <= ACCESS;
                end
                ACCESS: begin
                    if (bus.apb_ready) begin
                        if (!write) begin
                            if (owner) r1_rdata <= bus.apb_rdata;
                            else       r0_rdata <= bus.apb_rdata;
                        end
                        done     <= owner ? 2'b10 : 2'b01;
                        sel      <= '0;
                        enable   <= 1'b0;
                        wait_cnt <= '0;
                        state    <= IDLE;
                    end else if (wait_cnt == CNT_W'(WAIT_MAX - 1)) begin
                        // This low cycle is the WAIT_MAX-th in a row: abort.
                        done     <= owner ? 2'b10 : 2'b01;
                        err      <= owner ? 2'b10 : 2'b01;
                        sel      <= '0;
                        enable   <= 1'b0;
                        wait_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.apb_sel    = sel;
    assign bus.apb_enable = enable;
    assign bus.apb_write  = write;
    assign bus.apb_addr   = addr;
    assign bus.apb_wdata  = wdata;
    assign bus.r0_ack     = ack[0];
    assign bus.r1_ack     = ack[1];
    assign bus.r0_done    = done[0];
    assign bus.r1_done    = done[1];
    assign bus.r0_err     = err[0];
    assign bus.r1_err     = err[1];
    assign bus.r0_rdata   = r0_rdata;
    assign bus.r1_rdata   = r1_rdata;
endmodule

// File: tb/tb_apb_master_arbiter.sv
// Scoreboard bench for apb_master_arbiter: expected grants are queued at issue time
// and a monitor checks each ack, ACCESS cycle and completion against them.
module tb_apb_master_arbiter;
    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 8;
    localparam int WAIT_MAX = 16;

    typedef struct {
        bit         req;
        bit         write;
        logic [1:0] id;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] sdata;
        int         waits;
        bit         err;
    } cmd_t;

    logic clk;
    logic reset;

    apb_master_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    apb_master_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_MAX(WAIT_MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    int   n_compared   = 0;
    int   n_mismatched = 0;
    cmd_t req_q0[$];
    cmd_t req_q1[$];
    cmd_t grant_q[$];
    cmd_t cur;
    bit   in_xfer = 1'b0;
    int   since_ack;
    int   access_cycles;
    logic [7:0] model_rdata [2];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic cmd_t mk(input bit req, input bit write, input logic [1:0] id,
                                input logic [7:0] addr, input logic [7:0] wdata,
                                input logic [7:0] sdata, input int waits, input bit err);
        cmd_t c;
        c.req = req; c.write = write; c.id = id; c.addr = addr;
        c.wdata = wdata; c.sdata = sdata; c.waits = waits; c.err = err;
        return c;
    endfunction

    task automatic apply_stimulus(input cmd_t c);
        grant_q.push_back(c);
        if (c.req) req_q1.push_back(c);
        else       req_q0.push_back(c);
    endtask

    task automatic wait_drain(input int max_cycles, input string name);
        int n = 0;
        while ((grant_q.size() != 0 || in_xfer) && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        if (grant_q.size() != 0 || in_xfer) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL %s_timeout: %0d grants still pending after %0d cycles", name, grant_q.size(), max_cycles);
            grant_q.delete();
            req_q0.delete();
            req_q1.delete();
            in_xfer = 1'b0;
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
    endtask

    // Requester 0 driver: holds the head command until it is acked.
    initial begin
        bus.r0_valid = 1'b0; bus.r0_write = 1'b0; bus.r0_id = '0; bus.r0_addr = '0; bus.r0_wdata = '0;
        forever begin
            @(negedge clk);
            if (bus.r0_valid && bus.r0_ack) void'(req_q0.pop_front());
            if (req_q0.size() != 0) begin
                bus.r0_valid = 1'b1; bus.r0_write = req_q0[0].write; bus.r0_id = req_q0[0].id;
                bus.r0_addr = req_q0[0].addr; bus.r0_wdata = req_q0[0].wdata;
            end else begin
                bus.r0_valid = 1'b0;
            end
        end
    end

    initial begin
        bus.r1_valid = 1'b0; bus.r1_write = 1'b0; bus.r1_id = '0; bus.r1_addr = '0; bus.r1_wdata = '0;
        forever begin
            @(negedge clk);
            if (bus.r1_valid && bus.r1_ack) void'(req_q1.pop_front());
            if (req_q1.size() != 0) begin
                bus.r1_valid = 1'b1; bus.r1_write = req_q1[0].write; bus.r1_id = req_q1[0].id;
                bus.r1_addr = req_q1[0].addr; bus.r1_wdata = req_q1[0].wdata;
            end else begin
                bus.r1_valid = 1'b0;
            end
        end
    end

    // Slave model: ready stays low for the command's wait count of ACCESS cycles.
    initial begin
        int cnt = 0;
        bus.apb_ready = 1'b0;
        bus.apb_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.apb_enable) begin
                bus.apb_ready = (cnt >= cur.waits);
                bus.apb_rdata = cur.sdata;
                cnt++;
            end else begin
                bus.apb_ready = 1'b0;
                cnt = 0;
            end
        end
    end

    initial begin
        model_rdata[0] = '0;
        model_rdata[1] = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                in_xfer = 1'b0;
                model_rdata[0] = '0;
                model_rdata[1] = '0;
                continue;
            end
            check_output("sel_onehot0", 32'($onehot0(bus.apb_sel)), 1);
            check_output("done_exclusive", 32'(bus.r0_done & bus.r1_done), 0);
            if (in_xfer) since_ack++;
            if (bus.r0_ack || bus.r1_ack) begin
                if (grant_q.size() == 0 || in_xfer) begin
                    n_compared++;
                    n_mismatched++;
                    $display("[TB] FAIL unexpected_ack: r0_ack=%0b r1_ack=%0b, required none", bus.r0_ack, bus.r1_ack);
                end else begin
                    cur = grant_q.pop_front();
                    check_output("grant_req", {bus.r1_ack, bus.r0_ack}, cur.req ? 2'b10 : 2'b01);
                    check_output("setup_sel", bus.apb_sel, 4'b0001 << cur.id);
                    check_output("setup_enable", bus.apb_enable, 0);
                    check_output("setup_write", bus.apb_write, cur.write);
                    check_output("setup_addr", bus.apb_addr, cur.addr);
                    check_output("setup_wdata", bus.apb_wdata, cur.wdata);
                    in_xfer = 1'b1;
                    since_ack = 0;
                    access_cycles = 0;
                end
            end else if (in_xfer && bus.apb_enable) begin
                access_cycles++;
                check_output("access_sel", bus.apb_sel, 4'b0001 << cur.id);
                check_output("access_write", bus.apb_write, cur.write);
                check_output("access_addr", bus.apb_addr, cur.addr);
                check_output("access_wdata", bus.apb_wdata, cur.wdata);
                check_output("other_req_quiet",
                             cur.req ? {bus.r0_ack, bus.r0_done, bus.r0_err} : {bus.r1_ack, bus.r1_done, bus.r1_err}, 0);
            end
            if (bus.r0_done || bus.r1_done) begin
                if (!in_xfer) begin
                    n_compared++;
                    n_mismatched++;
                    $display("[TB] FAIL unexpected_done: r0_done=%0b r1_done=%0b, required none", bus.r0_done, bus.r1_done);
                end else begin
                    if (!cur.err && !cur.write) model_rdata[cur.req] = cur.sdata;
                    check_output("done_req", {bus.r1_done, bus.r0_done}, cur.req ? 2'b10 : 2'b01);
                    check_output("done_err", {bus.r1_err, bus.r0_err}, cur.err ? (cur.req ? 2'b10 : 2'b01) : 2'b00);
                    check_output("done_rdata", cur.req ? bus.r1_rdata : bus.r0_rdata, model_rdata[cur.req]);
                    check_output("done_latency", since_ack, cur.err ? WAIT_MAX + 1 : cur.waits + 2);
                    check_output("access_cycles", access_cycles, cur.err ? WAIT_MAX : cur.waits + 1);
                    check_output("done_bus_idle", {bus.apb_sel, bus.apb_enable}, 0);
                    in_xfer = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d grants pending", grant_q.size());
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_output("rst_sel", bus.apb_sel, 0);
        check_output("rst_enable", bus.apb_enable, 0);
        check_output("rst_write", bus.apb_write, 0);
        check_output("rst_addr", bus.apb_addr, 0);
        check_output("rst_wdata", bus.apb_wdata, 0);
        check_output("rst_r0", {bus.r0_ack, bus.r0_done, bus.r0_err, bus.r0_rdata}, 0);
        check_output("rst_r1", {bus.r1_ack, bus.r1_done, bus.r1_err, bus.r1_rdata}, 0);
        #1 reset = 1'b0;

        // Plain write, plain read, then a write with five wait states.
        @(posedge clk);
        apply_stimulus(mk(1'b0, 1'b1, 2'd1, 8'h06, 8'h05, 8'h00, 0, 1'b0));
        wait_drain(50, "t1_write");
        @(posedge clk);
        apply_stimulus(mk(1'b1, 1'b0, 2'd1, 8'h06, 8'h00, 8'h05, 0, 1'b0));
        wait_drain(50, "t2_read");
        @(posedge clk);
        apply_stimulus(mk(1'b0, 1'b1, 2'd0, 8'h05, 8'h04, 8'h00, 5, 1'b0));
        wait_drain(50, "t3_waits");

        // Both requesters busy from reset: grants must alternate r0, r1, r0, r1.
        reset_dut();
        @(posedge clk);
        apply_stimulus(mk(1'b0, 1'b1, 2'd2, 8'h10, 8'ha1, 8'h00, 0, 1'b0));
        apply_stimulus(mk(1'b1, 1'b0, 2'd3, 8'h20, 8'h00, 8'h3c, 1, 1'b0));
        apply_stimulus(mk(1'b0, 1'b0, 2'd0, 8'h11, 8'h00, 8'h77, 0, 1'b0));
        apply_stimulus(mk(1'b1, 1'b1, 2'd1, 8'h21, 8'h5a, 8'h00, 2, 1'b0));
        wait_drain(100, "t4_fairness");

        // Stuck slave times out, then the bus serves r1 normally.
        @(posedge clk);
        apply_stimulus(mk(1'b0, 1'b0, 2'd2, 8'h30, 8'h00, 8'hee, 100, 1'b1));
        wait_drain(60, "t5_timeout");
        @(posedge clk);
        apply_stimulus(mk(1'b1, 1'b1, 2'd0, 8'h31, 8'h99, 8'h00, 1, 1'b0));
        wait_drain(50, "t5_after");

        // Reset in the middle of a waited ACCESS abandons the command silently.
        @(posedge clk);
        apply_stimulus(mk(1'b0, 1'b0, 2'd1, 8'h40, 8'h00, 8'h12, 100, 1'b1));
        begin
            int n = 0;
            while (!bus.apb_enable && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        check_output("t6_enable_seen", bus.apb_enable, 1);
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check_output("t6_rst_bus", {bus.apb_sel, bus.apb_enable}, 0);
        check_output("t6_rst_r0", {bus.r0_ack, bus.r0_done, bus.r0_err}, 0);
        check_output("t6_rst_r1", {bus.r1_ack, bus.r1_done, bus.r1_err}, 0);
        grant_q.delete();
        #1 reset = 1'b0;
        @(negedge clk);
        check_output("t6_idle_bus", {bus.apb_sel, bus.apb_enable}, 0);
        check_output("t6_no_done", {bus.r0_done, bus.r0_err, bus.r1_done, bus.r1_err}, 0);
        @(posedge clk);
        apply_stimulus(mk(1'b1, 1'b0, 2'd3, 8'h50, 8'h00, 8'h42, 2, 1'b0));
        wait_drain(50, "t6_after_reset");

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
